// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM link: default frame geometry, the slot index
// type and the receive framing state. The transmit-side mux select counter
// uses the same constants, so both ends of the link agree on slot numbering.
// -----------------------------------------------------------------------------
package tdm_pkg;

    localparam int CHANNELS_DEF = 4;
    localparam int WIDTH_DEF    = 8;
    localparam int SEL_W_DEF    = $clog2(CHANNELS_DEF);

    typedef logic [SEL_W_DEF-1:0] slot_t;

    // HUNT: waiting for a frame_sync. LOCKED: tracking slot positions.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage : tdm_pkg

// File: rtl/tdm_slot_counter.sv
// -----------------------------------------------------------------------------
// tdm_slot_counter
// Slot index counter for the TDM receiver. Priority: clr > load1 > inc.
// Incrementing from the last slot wraps to 0.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (slot <= 0)
//   clr    in   force slot to 0
//   load1  in   force slot to 1 (slot 0 has just been consumed)
//   inc    in   advance slot, wrapping CHANNELS-1 -> 0
//   slot   out  current slot index
//   last   out  slot == CHANNELS-1
// -----------------------------------------------------------------------------
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter  int CHANNELS = CHANNELS_DEF,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [SEL_W-1:0] slot,
    output logic             last
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);

    assign last = (slot == LAST_SLOT);

    // NOTE: clocked state is always written with <= so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SEL_W'(1);
        end else if (inc) begin
            slot <= last ? '0 : slot + SEL_W'(1);
        end
    end

endmodule : tdm_slot_counter

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
// Receive-side TDM demultiplexer. Collects one WIDTH-bit sample per slot into
// shadow registers and, when the last slot arrives, transfers the whole frame
// to dout in one step so consumers never see a half-updated frame.
// frame_sync (qualified by din_valid) marks slot 0; violations pulse sync_err.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   din          in   sample for the current slot
//   din_valid    in   din carries a sample this cycle (no backpressure)
//   frame_sync   in   slot 0 marker, only meaningful with din_valid
//   dout         out  last complete frame, channel k at dout[k*WIDTH +: WIDTH]
//   frame_valid  out  one-cycle pulse when dout updates
//   sel          out  slot index expected for the next accepted sample
//   locked       out  framing state is LOCKED
//   sync_err     out  one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module tdm_demux
    import tdm_pkg::*;
#(
    parameter  int CHANNELS = CHANNELS_DEF,
    parameter  int WIDTH    = WIDTH_DEF,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      frame_valid,
    output logic [SEL_W-1:0]          sel,
    output logic                      locked,
    output logic                      sync_err
);

    state_e           state;
    logic [SEL_W-1:0] slot;
    logic             slot_last;
    logic             slot_zero;

    // Slots 0..CHANNELS-2 are staged here; the last slot goes straight to dout.
    logic [WIDTH-1:0] shadow [CHANNELS-1];

    // Counter control. A synced sample always restarts the frame at slot 1;
    // an unsynced sample in LOCKED either advances (mid-frame) or, at slot 0,
    // is a missing sync and the counter stays at 0 while we fall back to HUNT.
    logic accept_sync;
    logic accept_data;
    logic cnt_clr;
    logic cnt_load1;
    logic cnt_inc;

    assign slot_zero   = (slot == '0);
    assign accept_sync = din_valid & frame_sync;
    assign accept_data = din_valid & ~frame_sync & (state == LOCKED);
    assign cnt_load1   = accept_sync;
    assign cnt_inc     = accept_data & ~slot_zero;
    assign cnt_clr     = accept_data & slot_zero;

    tdm_slot_counter #(
        .CHANNELS (CHANNELS)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .slot  (slot),
        .last  (slot_last)
    );

    assign sel    = slot;
    assign locked = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            dout        <= '0;
            // NOTE: the shadow array is a handful of flops, not a RAM, so it
            // is cleared with everything else; a real memory would be left
            // unreset and guarded by the slot counter instead.
            shadow      <= '{default: '0};
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;

            if (din_valid) begin
                case (state)
                    HUNT: begin
                        // Unsynced samples are dropped until slot 0 shows up.
                        if (frame_sync) begin
                            shadow[0] <= din;
                            state     <= LOCKED;
                        end
                    end

                    LOCKED: begin
                        if (frame_sync) begin
                            // Sync mid-frame: abandon the partial frame and
                            // restart from this sample.
                            shadow[0] <= din;
                            if (!slot_zero) begin
                                sync_err <= 1'b1;
                            end
                        end else if (slot_zero) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                        end else if (slot_last) begin
                            for (int k = 0; k < CHANNELS - 1; k++) begin
                                dout[k*WIDTH +: WIDTH] <= shadow[k];
                            end
                            dout[(CHANNELS-1)*WIDTH +: WIDTH] <= din;
                            frame_valid <= 1'b1;
                        end else begin
                            for (int k = 1; k < CHANNELS - 1; k++) begin
                                if (slot == SEL_W'(k)) begin
                                    shadow[k] <= din;
                                end
                            end
                        end
                    end

                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule : tdm_demux
